maze_walker: RTL and testbench

Sequential multi-agent stepper for the maze game: holds position and status for NAGENT agents on a 2^XW × 2^XW wall map and advances every agent one cell per start request. Agents are processed one per cycle through a single shared move/collision datapath. Adds configurable map size, agent count, goal location, wall mode, a step counter and a start/done handshake. Sits between the input/direction logic and the display/score logic.

---
 rtl/maze_walker_if.sv | 30 +++
 rtl/maze_walker.sv | 168 ++++++++++++++++
 tb/tb_maze_walker.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_walker_if.sv
// Bundle between the direction/input logic (master) and maze_walker (slave):
// wall map, start/done handshake, latched directions and per-agent status.
interface maze_walker_if #(
  parameter int XW     = 3,
  parameter int NAGENT = 4
);
  localparam int W = 1 << XW;

  logic [W*W-1:0]         map_data;
  logic                   start;
  logic [2*NAGENT-1:0]    dirs;
  logic                   ready;
  logic                   done;
  logic [XW*NAGENT-1:0]   x_out;
  logic [XW*NAGENT-1:0]   y_out;
  logic [NAGENT-1:0]      alive_out;
  logic [NAGENT-1:0]      goal_out;
  logic                   all_done;
  logic [15:0]            step_count;

  modport master (
    output map_data, start, dirs,
    input  ready, done, x_out, y_out, alive_out, goal_out, all_done, step_count
  );

  modport slave (
    input  map_data, start, dirs,
    output ready, done, x_out, y_out, alive_out, goal_out, all_done, step_count
  );
endinterface

// File: rtl/maze_walker.sv
// Multi-agent maze stepper: one start request advances every agent one cell,
// one agent per cycle through a shared move/collision datapath.
module maze_walker #(
  parameter int XW         = 3,
  parameter int NAGENT     = 4,
  parameter int GOAL_X     = (1 << XW) - 1,
  parameter int GOAL_Y     = (1 << XW) - 1,
  parameter bit WALL_KILLS = 1'b1,
  parameter int STEP_W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  maze_walker_if.slave  bus
);

  localparam int IW = (NAGENT > 1) ? $clog2(NAGENT) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NAGENT - 1);
  localparam logic [XW:0]   ONE_C     = {{XW{1'b0}}, 1'b1};
  localparam logic [XW:0]   GOAL_X_C  = (XW+1)'(GOAL_X);
  localparam logic [XW:0]   GOAL_Y_C  = (XW+1)'(GOAL_Y);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [1:0]          dirs_q [NAGENT];
  logic [1:0]          dirs_d [NAGENT];
  logic [XW-1:0]       x_q [NAGENT];
  logic [XW-1:0]       x_d [NAGENT];
  logic [XW-1:0]       y_q [NAGENT];
  logic [XW-1:0]       y_d [NAGENT];
  logic [NAGENT-1:0]   alive_q, alive_d;
  logic [NAGENT-1:0]   goal_q, goal_d;
  logic [STEP_W-1:0]   cnt_q, cnt_d;

  logic [XW-1:0]       cur_x_s, cur_y_s;
  logic [1:0]          cur_dir_s;
  logic [XW:0]         cand_x_s, cand_y_s;
  logic [2*XW-1:0]     cell_s;
  logic                oob_s, wall_s, at_goal_s;
  logic [XW-1:0]       nx_s, ny_s;
  logic                nalive_s, ngoal_s;

  // Shared per-agent move/collision datapath for the agent selected by idx_q.
  always_comb begin
    cur_x_s   = x_q[idx_q];
    cur_y_s   = y_q[idx_q];
    cur_dir_s = dirs_q[idx_q];
    cand_x_s  = {1'b0, cur_x_s};
    cand_y_s  = {1'b0, cur_y_s};
    case (cur_dir_s)
      2'd0:    cand_x_s = {1'b0, cur_x_s} + ONE_C;
      2'd1:    cand_x_s = {1'b0, cur_x_s} - ONE_C;
      2'd2:    cand_y_s = {1'b0, cur_y_s} + ONE_C;
      2'd3:    cand_y_s = {1'b0, cur_y_s} - ONE_C;
      default: cand_x_s = {1'b0, cur_x_s};
    endcase
    // The extra top bit flags both W (overflow) and -1 (underflow).
    oob_s     = cand_x_s[XW] | cand_y_s[XW];
    cell_s    = {cand_y_s[XW-1:0], cand_x_s[XW-1:0]};
    wall_s    = bus.map_data[~cell_s];
    at_goal_s = (cand_x_s == GOAL_X_C) && (cand_y_s == GOAL_Y_C);

    nx_s     = cur_x_s;
    ny_s     = cur_y_s;
    nalive_s = alive_q[idx_q];
    ngoal_s  = goal_q[idx_q];
    if (!alive_q[idx_q]) begin
      nalive_s = 1'b0;
    end else if (goal_q[idx_q]) begin
      ngoal_s = 1'b1;
    end else if (oob_s) begin
      nalive_s = 1'b0;
    end else if (at_goal_s) begin
      nx_s    = cand_x_s[XW-1:0];
      ny_s    = cand_y_s[XW-1:0];
      ngoal_s = 1'b1;
    end else if (wall_s) begin
      nalive_s = ~WALL_KILLS;
    end else begin
      nx_s = cand_x_s[XW-1:0];
      ny_s = cand_y_s[XW-1:0];
    end
  end

  // Next-state logic: IDLE -> STEP (one agent per cycle) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dirs_d  = dirs_q;
    x_d     = x_q;
    y_d     = y_q;
    alive_d = alive_q;
    goal_d  = goal_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < NAGENT; i++) begin
            dirs_d[i] = bus.dirs[2*i +: 2];
          end
          idx_d   = '0;
          state_d = S_STEP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        x_d[idx_q]     = nx_s;
        y_d[idx_q]     = ny_s;
        alive_d[idx_q] = nalive_s;
        goal_d[idx_q]  = ngoal_s;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        cnt_d   = (cnt_q == {STEP_W{1'b1}}) ? cnt_q : cnt_q + STEP_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset to the start-of-game position.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      alive_q <= {NAGENT{1'b1}};
      goal_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < NAGENT; i++) begin
        dirs_q[i] <= 2'd0;
        x_q[i]    <= '0;
        y_q[i]    <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dirs_q  <= dirs_d;
      x_q     <= x_d;
      y_q     <= y_d;
      alive_q <= alive_d;
      goal_q  <= goal_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar g = 0; g < NAGENT; g++) begin : g_pack
    assign bus.x_out[XW*g +: XW] = x_q[g];
    assign bus.y_out[XW*g +: XW] = y_q[g];
  end

  assign bus.alive_out  = alive_q;
  assign bus.goal_out   = goal_q;
  assign bus.step_count = 16'(cnt_q);
  assign bus.ready      = (state_q == S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.all_done   = &(~alive_q | goal_q);

endmodule

// File: tb/tb_maze_walker.sv
// Directed self-checking bench for maze_walker: wall-kill and wall-block
// instances share stimulus; a narrow-counter instance exercises saturation.
module tb_maze_walker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  maze_walker_if #(.XW(3), .NAGENT(4)) bif ();
  maze_walker_if #(.XW(3), .NAGENT(4)) nif ();
  maze_walker_if #(.XW(3), .NAGENT(2)) sif ();

  maze_walker #(.XW(3), .NAGENT(4), .WALL_KILLS(1'b1)) u_dut (.clk(clk), .rst(rst), .bus(bif));
  maze_walker #(.XW(3), .NAGENT(4), .WALL_KILLS(1'b0)) u_nk  (.clk(clk), .rst(rst), .bus(nif));
  maze_walker #(.XW(3), .NAGENT(2), .STEP_W(4))        u_sat (.clk(clk), .rst(rst), .bus(sif));

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_map(input logic [63:0] m);
    bif.map_data = m;
    nif.map_data = m;
  endtask

  // Returns the cycle (1 = first cycle after the start edge) in which done was seen, 0 if never.
  task automatic do_step(input logic [7:0] d, output int cyc);
    @(negedge clk);
    bif.dirs = d; nif.dirs = d;
    bif.start = 1'b1; nif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0; nif.start = 1'b0;
    cyc = 0;
    for (int n = 1; n <= 12; n++) begin
      if (bif.done === 1'b1) begin
        cyc = n;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (bif.ready !== 1'b1 || bif.done !== 1'b0) begin
      n_errors++; $display("FAIL reset_hs: ready=%b done=%b expected 1 0", bif.ready, bif.done);
    end
    n_checks++;
    if (bif.x_out !== 12'h000 || bif.y_out !== 12'h000) begin
      n_errors++; $display("FAIL reset_pos: x=%h y=%h expected 000 000", bif.x_out, bif.y_out);
    end
    n_checks++;
    if (bif.alive_out !== 4'hF || bif.goal_out !== 4'h0 || bif.step_count !== 16'h0000 || bif.all_done !== 1'b0) begin
      n_errors++; $display("FAIL reset_flags: alive=%h goal=%h cnt=%h all_done=%b expected F 0 0000 0",
                           bif.alive_out, bif.goal_out, bif.step_count, bif.all_done);
    end
  endtask

  task automatic test_basic_step();
    int cyc;
    apply_reset();
    set_map(64'h0);
    do_step(8'h00, cyc);
    n_checks++;
    if (cyc !== 5) begin
      n_errors++; $display("FAIL basic_done_cycle: got %0d expected 5", cyc);
    end
    n_checks++;
    if (bif.done !== 1'b0 || bif.ready !== 1'b1) begin
      n_errors++; $display("FAIL basic_after: done=%b ready=%b expected 0 1", bif.done, bif.ready);
    end
    n_checks++;
    if (bif.x_out !== 12'h249 || bif.y_out !== 12'h000 || bif.alive_out !== 4'hF) begin
      n_errors++; $display("FAIL basic_pos: x=%h y=%h alive=%h expected 249 000 F", bif.x_out, bif.y_out, bif.alive_out);
    end
    n_checks++;
    if (bif.step_count !== 16'd1) begin
      n_errors++; $display("FAIL basic_count: got %0d expected 1", bif.step_count);
    end
  endtask

  task automatic test_wall();
    int cyc;
    apply_reset();
    set_map(64'h4000_0000_0000_0000);
    do_step(8'hA8, cyc);
    n_checks++;
    if (bif.alive_out !== 4'hE || bif.x_out !== 12'h000 || bif.y_out !== 12'h248) begin
      n_errors++; $display("FAIL wall_kill1: alive=%h x=%h y=%h expected E 000 248", bif.alive_out, bif.x_out, bif.y_out);
    end
    n_checks++;
    if (nif.alive_out !== 4'hF || nif.x_out !== 12'h000 || nif.y_out !== 12'h248) begin
      n_errors++; $display("FAIL wall_block1: alive=%h x=%h y=%h expected F 000 248", nif.alive_out, nif.x_out, nif.y_out);
    end
    do_step(8'hA8, cyc);
    n_checks++;
    if (bif.alive_out !== 4'hE || bif.x_out !== 12'h000 || bif.y_out !== 12'h490 || bif.step_count !== 16'd2) begin
      n_errors++; $display("FAIL wall_kill2: alive=%h x=%h y=%h cnt=%0d expected E 000 490 2",
                           bif.alive_out, bif.x_out, bif.y_out, bif.step_count);
    end
    n_checks++;
    if (nif.alive_out !== 4'hF || nif.x_out !== 12'h000 || nif.y_out !== 12'h490) begin
      n_errors++; $display("FAIL wall_block2: alive=%h x=%h y=%h expected F 000 490", nif.alive_out, nif.x_out, nif.y_out);
    end
  endtask

  task automatic test_edge();
    int cyc;
    apply_reset();
    set_map(64'h0);
    do_step(8'h0D, cyc);
    n_checks++;
    if (bif.alive_out !== 4'hC || bif.x_out !== 12'h240 || bif.y_out !== 12'h000) begin
      n_errors++; $display("FAIL edge_kill: alive=%h x=%h y=%h expected C 240 000", bif.alive_out, bif.x_out, bif.y_out);
    end
    n_checks++;
    if (nif.alive_out !== 4'hC) begin
      n_errors++; $display("FAIL edge_kill_nk: alive=%h expected C", nif.alive_out);
    end
  endtask

  task automatic test_goal();
    int cyc;
    apply_reset();
    set_map(64'h0000_0000_0000_0001);
    for (int s = 0; s < 7; s++) do_step(8'h56, cyc);
    for (int s = 0; s < 6; s++) do_step(8'h54, cyc);
    n_checks++;
    if (bif.x_out[2:0] !== 3'd6 || bif.y_out[2:0] !== 3'd7 || bif.alive_out !== 4'h1 || bif.all_done !== 1'b0) begin
      n_errors++; $display("FAIL goal_approach: x0=%0d y0=%0d alive=%h all_done=%b expected 6 7 1 0",
                           bif.x_out[2:0], bif.y_out[2:0], bif.alive_out, bif.all_done);
    end
    do_step(8'h54, cyc);
    n_checks++;
    if (bif.x_out !== 12'h007 || bif.y_out !== 12'h007 || bif.goal_out !== 4'h1 || bif.alive_out !== 4'h1) begin
      n_errors++; $display("FAIL goal_reach: x=%h y=%h goal=%h alive=%h expected 007 007 1 1",
                           bif.x_out, bif.y_out, bif.goal_out, bif.alive_out);
    end
    n_checks++;
    if (bif.all_done !== 1'b1 || nif.goal_out !== 4'h1) begin
      n_errors++; $display("FAIL goal_all_done: all_done=%b nk_goal=%h expected 1 1", bif.all_done, nif.goal_out);
    end
    do_step(8'h55, cyc);
    n_checks++;
    if (bif.x_out !== 12'h007 || bif.goal_out !== 4'h1 || bif.alive_out !== 4'h1 || bif.step_count !== 16'd15) begin
      n_errors++; $display("FAIL goal_hold: x=%h goal=%h alive=%h cnt=%0d expected 007 1 1 15",
                           bif.x_out, bif.goal_out, bif.alive_out, bif.step_count);
    end
  endtask

  task automatic test_start_during_step();
    int seen;
    apply_reset();
    set_map(64'h0);
    @(negedge clk);
    bif.dirs = 8'h00; bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    @(negedge clk);
    bif.dirs = 8'hAA; bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      if (bif.done === 1'b1) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 1 || bif.step_count !== 16'd1) begin
      n_errors++; $display("FAIL ignore_start: done_pulses=%0d cnt=%0d expected 1 1", seen, bif.step_count);
    end
    n_checks++;
    if (bif.x_out !== 12'h249 || bif.y_out !== 12'h000) begin
      n_errors++; $display("FAIL ignore_start_pos: x=%h y=%h expected 249 000", bif.x_out, bif.y_out);
    end
  endtask

  task automatic test_reset_mid_step();
    int cyc;
    int seen;
    apply_reset();
    set_map(64'h0);
    do_step(8'h00, cyc);
    @(negedge clk);
    bif.dirs = 8'h00; bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bif.x_out !== 12'h000 || bif.alive_out !== 4'hF || bif.step_count !== 16'd0 || bif.ready !== 1'b1) begin
      n_errors++; $display("FAIL mid_reset: x=%h alive=%h cnt=%0d ready=%b expected 000 F 0 1",
                           bif.x_out, bif.alive_out, bif.step_count, bif.ready);
    end
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      if (bif.done === 1'b1) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 0 || bif.step_count !== 16'd0) begin
      n_errors++; $display("FAIL mid_reset_nodone: done_pulses=%0d cnt=%0d expected 0 0", seen, bif.step_count);
    end
  endtask

  task automatic test_saturation();
    bit tmo;
    apply_reset();
    sif.map_data = 64'h0;
    sif.dirs = 4'h0;
    tmo = 1'b0;
    for (int s = 1; s <= 18; s++) begin
      @(negedge clk);
      sif.start = 1'b1;
      @(negedge clk);
      sif.start = 1'b0;
      for (int n = 0; n < 8 && sif.done !== 1'b1; n++) @(negedge clk);
      if (sif.done !== 1'b1) tmo = 1'b1;
      @(negedge clk);
      if (s == 14) begin
        n_checks++;
        if (sif.step_count !== 16'd14) begin
          n_errors++; $display("FAIL sat_14: got %0d expected 14", sif.step_count);
        end
      end
      if (s == 15) begin
        n_checks++;
        if (sif.step_count !== 16'd15) begin
          n_errors++; $display("FAIL sat_15: got %0d expected 15", sif.step_count);
        end
      end
    end
    n_checks++;
    if (sif.step_count !== 16'd15 || tmo) begin
      n_errors++; $display("FAIL sat_hold: got %0d timeout=%b expected 15 0", sif.step_count, tmo);
    end
  endtask

  initial begin
    bif.start = 1'b0; nif.start = 1'b0; sif.start = 1'b0;
    bif.dirs = 8'h00; nif.dirs = 8'h00; sif.dirs = 4'h0;
    bif.map_data = 64'h0; nif.map_data = 64'h0; sif.map_data = 64'h0;
    test_reset();
    test_basic_step();
    test_wall();
    test_edge();
    test_goal();
    test_start_during_step();
    test_reset_mid_step();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
